bram_read_arbiter: RTL and testbench
====================================

Name: bram_read_arbiter

Overview:
Shares the single read port of the image frame BRAM (8192 x 8-bit, 13-bit address) between several consumers, such as the pixel-processing kernel, the UART transmit path and the debug readback.
- Round-robin arbitration with bounded bursts.
- Registered address to the BRAM.
- Read data returned with a per-requester valid strobe at fixed latency.
- Sits between the consumers and the BRAM read port; the write side stays with the existing BRAM write controller.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
ADDR_W, 13, BRAM address width
DATA_W, 8, pixel/data width
READ_LAT, 1, BRAM read latency in cycles from registered address to valid data (1..3)
MAX_BURST, 4, max consecutive accepted reads per owner while others wait (1..16)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high
req_i  input  NUM_REQ  per-requester read request, held until granted
addr_i  input  NUM_REQ*ADDR_W  per-requester address; slice i = [i*ADDR_W +: ADDR_W]
gnt_o  output  NUM_REQ  one-hot (or zero) grant, combinational from req_i and arbiter state
rvalid_o  output  NUM_REQ  one-hot strobe: rdata_o belongs to requester i this cycle
rdata_o  output  DATA_W  read data, direct pass-through of bram_rdata_i
bram_addr_o  output  ADDR_W  registered BRAM read address
bram_en_o  output  1  registered BRAM read enable
bram_rdata_i  input  DATA_W  BRAM read data
write_busy_i  input  1  write controller mid-write indicator (used only with the optional feature)

Behaviour:
- Reset values: gnt_o=0, rvalid_o=0, bram_addr_o=0, bram_en_o=0, priority pointer=0, burst count=0, state=IDLE. The valid pipeline is cleared.
- Accept: a beat is accepted at a rising edge where req_i[i] & gnt_o[i]. The requester samples gnt_o in the same cycle, then drops or changes its request/address for the next beat.
- Latency: beat accepted at edge T gives:
  - bram_addr_o = addr_i slice and bram_en_o = 1 in cycle T+1;
  - rvalid_o[i] = 1 in cycle T+1+READ_LAT.
  - Requester id travels through a READ_LAT-deep shift pipeline alongside the valid bit.
- bram_en_o = 0 in any cycle following an edge with no accept. bram_addr_o holds its last value.
- Throughput: one accept per cycle max, back-to-back allowed.
- State machine:
  - IDLE: grant goes to the first requesting index at or after the pointer, wrapping modulo NUM_REQ. On accept: owner = that index, burst count = 1, go to OWNED.
  - OWNED: gnt_o = owner while req_i[owner] = 1 and burst count < MAX_BURST.
  - Each accept increments the burst count (saturating at MAX_BURST).
  - Owner drops req: pointer = owner+1 (mod NUM_REQ). In the same cycle, grant the next requester by the IDLE rule. If one is accepted, it becomes the new owner with count 1; else go to IDLE.
  - Count reaches MAX_BURST and another requester is pending: same rotation as the drop case.
  - Count reaches MAX_BURST and no other requester is pending: count reset to 0, owner keeps the grant.
- Wrap: pointer wraps NUM_REQ-1 -> 0. An index equal to NUM_REQ never occurs.
- Simultaneous requests in IDLE: lowest index at or after the pointer wins. The others wait with req held; there is no starvation, because the wait is bounded by (NUM_REQ-1)*MAX_BURST accepts.
- Reset mid-operation: in-flight reads are discarded, and no rvalid_o is asserted after reset for beats accepted before it.
- Addresses are passed unmodified; there is no range check (13 bits covers the full BRAM).

Optional Feature:
BRAM_READ_WRITE_FENCE_EN
- Defined: while write_busy_i = 1, gnt_o is forced to 0 and no beat is accepted.
  - Owner, pointer and burst count are frozen.
  - Reads already in flight complete normally.
  - Arbitration resumes in the first cycle write_busy_i = 0.
- Undefined: write_busy_i is ignored (port kept, unused). Reads are never stalled by writes.

Test Plan:
1. Single requester 0 reads address 0x0005, BRAM model returns 0xA5 -> gnt_o=001 same cycle; bram_addr_o=0x0005, bram_en_o=1 next cycle; rvalid_o=001 with rdata_o=0xA5 two cycles after accept (READ_LAT=1).
2. Requests 0, 1, 2 all held continuously from reset, MAX_BURST=4 -> grant sequence 0,0,0,0,1,1,1,1,2,2,2,2,0; rvalid ids follow the same sequence delayed by 2 cycles.
3. Requester 2 alone holds req for 10 beats, addresses 0x1FF8..0x1FFF,0x0000,0x0001 -> uninterrupted grant (count resets at 4); every address appears on bram_addr_o in order.
4. Pointer=2 (after serving 1); requesters 0 and 2 request in the same cycle -> 2 granted first, then 0.
5. Reset asserted one cycle after accept of requester 1 -> no rvalid_o; all outputs 0 the following cycle; pointer restarts at 0.
6. With BRAM_READ_WRITE_FENCE_EN, write_busy_i=1 for 3 cycles during requester 0 burst -> gnt_o=000 for those 3 cycles, the prior in-flight read still returns valid, the burst resumes with count preserved. Without the macro -> no stall.

Source files
------------

// File: rtl/bram_read_arbiter.sv
// Round-robin, burst-bounded arbiter sharing the frame BRAM read port between NUM_REQ consumers.
// Optional macro BRAM_READ_WRITE_FENCE_EN: stall all grants while the write controller is mid-write.
module bram_read_arbiter #(
    parameter int unsigned NUM_REQ   = 3,
    parameter int unsigned ADDR_W    = 13,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned READ_LAT  = 1,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [NUM_REQ*ADDR_W-1:0]  addr_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [NUM_REQ-1:0]         rvalid_o,
    output logic [DATA_W-1:0]          rdata_o,
    output logic [ADDR_W-1:0]          bram_addr_o,
    output logic                       bram_en_o,
    input  logic [DATA_W-1:0]          bram_rdata_i,
    input  logic                       write_busy_i
);

    localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CW  = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE,
        OWNED
    } state_t;

    state_t                     state_q, state_d;
    logic [IDW-1:0]             owner_q, owner_d;
    logic [IDW-1:0]             ptr_q, ptr_d;
    logic [CW-1:0]              cnt_q, cnt_d;

    logic                       gnt_v;
    logic [IDW-1:0]             gnt_idx;
    logic                       accept;
    logic                       fence;
    logic [IDW:0]               pk;
    logic [IDW-1:0]             nxt;
    logic [NUM_REQ-1:0]         others;

    logic [ADDR_W-1:0]          baddr_q;
    logic                       ben_q;
    logic [IDW-1:0]             bid_q;
    logic [READ_LAT-1:0]        vld_q;
    logic [READ_LAT*IDW-1:0]    vid_q;

`ifdef BRAM_READ_WRITE_FENCE_EN
    assign fence = write_busy_i;
`else
    logic unused_write_busy;
    assign unused_write_busy = write_busy_i;
    assign fence = 1'b0;
`endif

    // Returns {found, index} of the first requester at or after start, wrapping.
    function automatic logic [IDW:0] pick(input logic [NUM_REQ-1:0] r, input logic [IDW-1:0] start);
        logic [IDW:0] res;
        int unsigned  idx;
        res = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(start) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!res[IDW] && r[idx[IDW-1:0]]) res = {1'b1, idx[IDW-1:0]};
        end
        return res;
    endfunction

    function automatic logic [IDW-1:0] inc_wrap(input logic [IDW-1:0] v);
        return (32'(v) == NUM_REQ - 1) ? '0 : v + 1'b1;
    endfunction

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt_v   = 1'b0;
        gnt_idx = owner_q;
        pk      = '0;
        nxt     = inc_wrap(owner_q);
        others  = req_i & ~(NUM_REQ'(1) << owner_q);

        case (state_q)
            IDLE: begin
                pk      = pick(req_i, ptr_q);
                gnt_v   = pk[IDW];
                gnt_idx = pk[IDW-1:0];
                if (pk[IDW]) begin
                    state_d = OWNED;
                    owner_d = pk[IDW-1:0];
                    cnt_d   = CW'(1);
                end
            end
            OWNED: begin
                if (req_i[owner_q] && (cnt_q < CW'(MAX_BURST))) begin
                    gnt_v = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                end else if (req_i[owner_q] && (others == '0)) begin
                    // Burst limit hit with nobody waiting: count restarts, this beat is the first.
                    gnt_v = 1'b1;
                    cnt_d = CW'(1);
                end else begin
                    ptr_d   = nxt;
                    pk      = pick(req_i, nxt);
                    gnt_v   = pk[IDW];
                    gnt_idx = pk[IDW-1:0];
                    if (pk[IDW]) begin
                        owner_d = pk[IDW-1:0];
                        cnt_d   = CW'(1);
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A write fence freezes all arbitration state and withholds the grant.
        if (fence) begin
            state_d = state_q;
            owner_d = owner_q;
            ptr_d   = ptr_q;
            cnt_d   = cnt_q;
            gnt_v   = 1'b0;
        end
    end

    assign accept = gnt_v & ~reset;
    assign gnt_o  = accept ? (NUM_REQ'(1) << gnt_idx) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            baddr_q <= '0;
            ben_q   <= 1'b0;
            bid_q   <= '0;
            vld_q   <= '0;
            vid_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            ben_q   <= accept;
            bid_q   <= gnt_idx;
            if (accept) baddr_q <= addr_i[gnt_idx*ADDR_W +: ADDR_W];
            vld_q   <= (vld_q << 1) | READ_LAT'(ben_q);
            vid_q   <= (vid_q << IDW) | (READ_LAT*IDW)'(bid_q);
        end
    end

    assign bram_addr_o = baddr_q;
    assign bram_en_o   = ben_q;
    assign rvalid_o    = vld_q[READ_LAT-1] ? (NUM_REQ'(1) << vid_q[(READ_LAT-1)*IDW +: IDW]) : '0;
    assign rdata_o     = bram_rdata_i;

endmodule

// File: tb/tb_bram_read_arbiter.sv
// Self-checking bench for bram_read_arbiter: per-cycle model compare plus directed literal checks.
module tb_bram_read_arbiter;

    localparam int N    = 3;
    localparam int AW   = 13;
    localparam int DW   = 8;
    localparam int LAT  = 1;
    localparam int MAXB = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [N-1:0]      req_i = '0;
    logic [N*AW-1:0]   addr_i = '0;
    logic              write_busy_i = 1'b0;
    logic [DW-1:0]     bram_rdata_i = '0;
    logic [N-1:0]      gnt_o;
    logic [N-1:0]      rvalid_o;
    logic [DW-1:0]     rdata_o;
    logic [AW-1:0]     bram_addr_o;
    logic              bram_en_o;

    bram_read_arbiter #(
        .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .READ_LAT(LAT), .MAX_BURST(MAXB)
    ) dut (
        .clk(clk), .reset(reset), .req_i(req_i), .addr_i(addr_i), .gnt_o(gnt_o),
        .rvalid_o(rvalid_o), .rdata_o(rdata_o), .bram_addr_o(bram_addr_o),
        .bram_en_o(bram_en_o), .bram_rdata_i(bram_rdata_i), .write_busy_i(write_busy_i)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] bval(input logic [AW-1:0] a);
        return a[7:0] ^ 8'hA0;
    endfunction

    // BRAM with one cycle of read latency
    always @(posedge clk) if (bram_en_o) bram_rdata_i <= bval(bram_addr_o);

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Requester agents: hold request until granted, then advance address or drop.
    int              rem [N];
    logic [AW-1:0]   a_r [N] = '{default: '0};
    logic [N-1:0]    acc_q = '0;

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc_q[i]) begin
                rem[i]--;
                a_r[i]++;
            end
            req_i[i] = (rem[i] > 0);
            addr_i[i*AW +: AW] = a_r[i];
        end
    end

    task automatic start_burst(input int i, input int n, input logic [AW-1:0] base);
        rem[i] = n;
        a_r[i] = base;
        req_i[i] = (n > 0);
        addr_i[i*AW +: AW] = base;
    endtask

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while ((rem[0] != 0 || rem[1] != 0 || rem[2] != 0) && k < budget) begin
            step;
            k++;
        end
        chk("wait_done_in_budget", 32'(k < budget), 32'd1);
    endtask

    function automatic int first_from(input logic [N-1:0] r, input int s);
        for (int k = 0; k < N; k++) if (r[(s + k) % N]) return (s + k) % N;
        return -1;
    endfunction

    function automatic int oh2i(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) if (v[k]) return k;
        return -1;
    endfunction

    // Logs of observed events for the directed literal checks
    int            gq[$], gc[$], rq[$], rc[$], ac[$];
    logic [AW-1:0] aq[$];
    logic [7:0]    dq[$];

    // Model: owner/streak/pointer bookkeeping, expected outputs scheduled in a ring by cycle
    int            cyc = 0;
    int            m_owner = -1, m_ptr = 0, m_streak = 0;
    bit            en_r [8];
    bit            au_r [8];
    logic [AW-1:0] av_r [8];
    bit            rv_r [8];
    int            rid_r [8];
    logic [7:0]    rd_r [8];
    logic [AW-1:0] last_addr = '0;

    always @(negedge clk) begin
        int            s, g, so;
        bit            rot, fen;
        logic [N-1:0]  oth;
        logic [AW-1:0] ga;
        cyc++;
        s = cyc % 8;
        if (au_r[s]) last_addr = av_r[s];
        chk("bram_en", 32'(bram_en_o), 32'(en_r[s]));
        chk("bram_addr", 32'(bram_addr_o), 32'(last_addr));
        chk("rvalid", 32'(rvalid_o), rv_r[s] ? (32'd1 << rid_r[s]) : 32'd0);
        if (rv_r[s]) chk("rdata", 32'(rdata_o), 32'(rd_r[s]));
        en_r[s] = 0; au_r[s] = 0; rv_r[s] = 0;

`ifdef BRAM_READ_WRITE_FENCE_EN
        fen = write_busy_i;
`else
        fen = 1'b0;
`endif
        g = -1;
        rot = 0;
        if (!reset && !fen) begin
            if (m_owner < 0) g = first_from(req_i, m_ptr);
            else begin
                oth = req_i & ~(N'(1) << m_owner);
                if (req_i[m_owner] && (m_streak < MAXB || oth == '0)) g = m_owner;
                else begin
                    rot = 1;
                    g = first_from(req_i, (m_owner + 1) % N);
                end
            end
        end
        chk("gnt", 32'(gnt_o), (g >= 0) ? (32'd1 << g) : 32'd0);

        if (|(gnt_o & req_i)) begin gq.push_back(oh2i(gnt_o)); gc.push_back(cyc); end
        if (bram_en_o) begin aq.push_back(bram_addr_o); ac.push_back(cyc); end
        if (|rvalid_o) begin rq.push_back(oh2i(rvalid_o)); rc.push_back(cyc); dq.push_back(rdata_o); end
        acc_q = gnt_o & req_i;

        if (reset) begin
            m_owner = -1; m_ptr = 0; m_streak = 0;
            for (int k = 1; k < 8; k++) begin
                so = (cyc + k) % 8;
                en_r[so] = 0; au_r[so] = 0; rv_r[so] = 0;
            end
            au_r[(cyc + 1) % 8] = 1;
            av_r[(cyc + 1) % 8] = '0;
        end else if (!fen) begin
            if (rot) m_ptr = (m_owner + 1) % N;
            if (g < 0) begin
                if (rot) m_owner = -1;
            end else begin
                if (g == m_owner) m_streak = (m_streak == MAXB) ? 1 : m_streak + 1;
                else begin
                    m_owner = g;
                    m_streak = 1;
                end
                ga = addr_i[g*AW +: AW];
                en_r[(cyc + 1) % 8] = 1;
                au_r[(cyc + 1) % 8] = 1;
                av_r[(cyc + 1) % 8] = ga;
                rv_r[(cyc + 1 + LAT) % 8] = 1;
                rid_r[(cyc + 1 + LAT) % 8] = g;
                rd_r[(cyc + 1 + LAT) % 8] = bval(ga);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b, ba, br, e2[15], e4[3], e6[8];
        logic [AW-1:0] a4[3], a5[3];
        e2 = '{0,0,0,0,1,1,1,1,2,2,2,2,0,1,2};
        e4 = '{1,2,0};
        a4 = '{13'h0100, 13'h0020, 13'h0010};
        a5 = '{13'h0055, 13'h0030, 13'h0031};
        e6 = '{0,0,0,0,1,1,0,0};

        reset = 1'b1;
        repeat (3) step;
        reset = 1'b0;
        step;

        // 1: single beat from requester 0
        b = gq.size(); ba = aq.size(); br = rq.size();
        start_burst(0, 1, 13'h0005);
        wait_done(50);
        repeat (4) step;
        chk("t1_ngnt", 32'(gq.size() - b), 32'd1);
        chk("t1_gnt_id", 32'(gq[b]), 32'd0);
        chk("t1_addr", 32'(aq[ba]), 32'h5);
        chk("t1_addr_lat", 32'(ac[ba] - gc[b]), 32'd1);
        chk("t1_rv_id", 32'(rq[br]), 32'd0);
        chk("t1_rv_lat", 32'(rc[br] - gc[b]), 32'd2);
        chk("t1_rdata", 32'(dq[br]), 32'hA5);

        // 2: three requesters held from reset
        reset = 1'b1;
        start_burst(0, 5, 13'h0100);
        start_burst(1, 5, 13'h0200);
        start_burst(2, 5, 13'h0300);
        step; step;
        b = gq.size(); ba = aq.size(); br = rq.size();
        reset = 1'b0;
        wait_done(100);
        repeat (4) step;
        chk("t2_ngnt", 32'(gq.size() - b), 32'd15);
        for (int k = 0; k < 15; k++) begin
            chk("t2_gnt_seq", 32'(gq[b + k]), 32'(e2[k]));
            chk("t2_rv_seq", 32'(rq[br + k]), 32'(e2[k]));
            chk("t2_rv_lat", 32'(rc[br + k] - gc[b + k]), 32'd2);
        end
        chk("t2_addr_owner1", 32'(aq[ba + 4]), 32'h0200);

        // 3: long burst wrapping the address space
        b = gq.size(); ba = aq.size();
        start_burst(2, 10, 13'h1FF8);
        wait_done(60);
        repeat (4) step;
        chk("t3_ngnt", 32'(gq.size() - b), 32'd10);
        for (int k = 0; k < 10; k++) begin
            chk("t3_gnt", 32'(gq[b + k]), 32'd2);
            chk("t3_addr", 32'(aq[ba + k]), (32'h1FF8 + 32'(k)) & 32'h1FFF);
        end
        chk("t3_no_gap", 32'(gc[b + 9] - gc[b]), 32'd9);

        // 4: pointer after serving 1, then 0 and 2 together
        b = gq.size(); ba = aq.size();
        start_burst(1, 1, 13'h0100);
        wait_done(20);
        repeat (3) step;
        start_burst(0, 1, 13'h0010);
        start_burst(2, 1, 13'h0020);
        wait_done(20);
        repeat (4) step;
        chk("t4_ngnt", 32'(gq.size() - b), 32'd3);
        for (int k = 0; k < 3; k++) begin
            chk("t4_gnt", 32'(gq[b + k]), 32'(e4[k]));
            chk("t4_addr", 32'(aq[ba + k]), 32'(a4[k]));
        end

        // 5: reset right after an accept
        b = gq.size(); ba = aq.size(); br = rq.size();
        start_burst(1, 1, 13'h0055);
        step;
        reset = 1'b1;
        step;
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk("t5_gnt_zero", 32'(gnt_o), 32'd0);
        chk("t5_en_zero", 32'(bram_en_o), 32'd0);
        chk("t5_addr_zero", 32'(bram_addr_o), 32'd0);
        chk("t5_rv_zero", 32'(rvalid_o), 32'd0);
        step;
        start_burst(0, 1, 13'h0030);
        start_burst(2, 1, 13'h0031);
        wait_done(20);
        repeat (4) step;
        chk("t5_ngnt", 32'(gq.size() - b), 32'd3);
        chk("t5_nrv", 32'(rq.size() - br), 32'd2);
        chk("t5_rv_first", 32'(rq[br]), 32'd0);
        for (int k = 0; k < 3; k++) chk("t5_addr", 32'(aq[ba + k]), 32'(a5[k]));
        chk("t5_gnt_after", 32'(gq[b + 1]), 32'd0);

        // 6: write_busy pulse mid-burst
        b = gq.size();
        start_burst(0, 6, 13'h0040);
        start_burst(1, 2, 13'h0050);
        begin
            int k;
            k = 0;
            while (rem[0] != 4 && k < 20) begin step; k++; end
            chk("t6_reach_beat2", 32'(k < 20), 32'd1);
        end
        write_busy_i = 1'b1;
        repeat (3) step;
        write_busy_i = 1'b0;
        wait_done(60);
        repeat (4) step;
        chk("t6_ngnt", 32'(gq.size() - b), 32'd8);
        for (int k = 0; k < 8; k++) chk("t6_gnt", 32'(gq[b + k]), 32'(e6[k]));
`ifdef BRAM_READ_WRITE_FENCE_EN
        chk("t6_span", 32'(gc[b + 7] - gc[b]), 32'd10);
`else
        chk("t6_span", 32'(gc[b + 7] - gc[b]), 32'd7);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
